fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline. It sits directly upstream of the decode stage and consumes the stall/flush and redirect controls issued by the hazard unit. It owns the PC, drives a variable-latency instruction-memory request/response interface with one request outstanding, and buffers one returned instruction. It produces the IF/ID pipeline register (`pc_ID`, `inst_ID`, `valid_ID`).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `NOP`, default 32'h0000_0013: instruction word loaded into ID on a bubble (addi x0,x0,0).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_IF`, `flush_IF`, `stall_ID`, `flush_ID`  in  1 each  hazard-unit controls.
- `redirect_EX`  in  1  taken branch or jalr resolved in EX.
- `target_EX`  in  32  redirect target from EX.
- `redirect_ID`  in  1  jal decoded in ID.
- `target_ID`  in  32  jal target from ID.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid. It arrives no earlier than the cycle after the grant.
- `imem_rdata`  in  32  instruction word.
- `pc_ID`  out  32  IF/ID PC.
- `inst_ID`  out  32  IF/ID instruction.
- `valid_ID`  out  1  IF/ID holds a real instruction.

## Operation
- **Registers:**
  - `pc_IF`: next address to fetch.
  - `req_pc`: address of the outstanding request.
  - fetch FSM.
  - one-entry buffer: `buf_valid`, `buf_pc`, `buf_inst`.
  - IF/ID register.
- **FSM states:**
  - IDLE: no outstanding request.
  - WAIT: request granted, response pending.
  - DROP: outstanding request is stale; its response will be discarded.
- `redir = redirect_EX | redirect_ID`. The effective target is `target_EX` if `redirect_EX` is set, else `target_ID`. EX has priority over ID.
- `drain = buf_valid & !stall_ID & !flush_ID & !redir`.
- `imem_req = (state==IDLE) & (!buf_valid | drain) & !redir & !stall_IF`.
- `imem_addr = pc_IF`.
- **IDLE:**
  - `imem_req & imem_gnt`: `req_pc <= pc_IF`, go to WAIT.
  - `imem_rvalid` in IDLE is ignored.
- **WAIT:**
  - `imem_rvalid & !redir & !flush_IF`: `buf_valid <= 1`, `buf_pc <= req_pc`, `buf_inst <= imem_rdata`, `pc_IF <= req_pc + 4` (mod 2^32), go to IDLE.
  - `imem_rvalid` together with redir or `flush_IF`: discard the response, go to IDLE.
  - redir or `flush_IF` without `imem_rvalid`: go to DROP.
- **DROP:**
  - `imem_rvalid`: discard, go to IDLE.
  - No new request is issued while in DROP.
- **Redirect:** `pc_IF <= effective target`, `buf_valid <= 0`.
- **`flush_IF` without redir:**
  - `buf_valid <= 0`.
  - `pc_IF` <= oldest unconsumed PC: `buf_pc` if `buf_valid`; else `req_pc` if in WAIT; else unchanged.
- **Update priority for `pc_IF` and the buffer:** redir > `flush_IF` > normal fetch.
- **IF/ID register:**
  - `flush_ID`: `valid_ID <= 0`, `inst_ID <= NOP`, `pc_ID` unchanged.
  - else `stall_ID`: hold all fields.
  - else `drain`: load `buf_pc` / `buf_inst`, `valid_ID <= 1`, and `buf_valid <= 0` unless refilled in the same cycle.
  - else: bubble (`valid_ID <= 0`, `inst_ID <= NOP`).
  - `flush_ID` overrides `stall_ID`.
- **Buffer occupancy:** a response can only arrive while the buffer is empty or draining, so the buffer never overflows.

## Timing
- **Reset (asynchronous, immediate):**
  - `pc_IF = RESET_PC`, state IDLE, `buf_valid = 0`.
  - `valid_ID = 0`, `inst_ID = NOP`, `pc_ID = 0`.
  - `imem_req` is forced to 0 while `rst` = 0.
- First request is issued in the first cycle with `rst` = 1.
- **Throughput:** with a zero-wait grant and 1-cycle response, one instruction reaches ID every 2 cycles. First valid `pc_ID = RESET_PC` appears 3 cycles after reset release.
- While `imem_req` = 1 and `imem_gnt` = 0, `imem_addr` is held stable unless redir or `stall_IF` occurs. Memory samples the address only on a grant cycle.
- Redirect in cycle N from IDLE: `imem_addr = target` in cycle N+1. From WAIT, the request is issued in the cycle after the stale response arrives.
- Reset asserted mid-WAIT or mid-DROP: any later `imem_rvalid` is ignored, because the FSM is in IDLE.

## Test plan
- **Reset and streaming:** `RESET_PC` = 0, zero-wait grant, 1-cycle memory returning `rdata` = addr -> `pc_ID` = 0, 4, 8 with `valid_ID` = 1 in cycles 3, 5, 7 after release; `inst_ID` = `pc_ID`.
- **Load-use stall:** `stall_IF` = `stall_ID` = 1 for 3 cycles with the buffer full (`buf_pc` = 8) -> `pc_ID` = 4 held, `imem_req` = 0; after release `pc_ID` = 8, then 0xC.
- **Redirect with late response:** `redirect_EX`, `target_EX` = 0x100 in WAIT; response 4 cycles late -> FSM in DROP; response discarded; next `imem_addr` = 0x100; `pc_ID` is never the stale PC.
- **Simultaneous redirects:** `redirect_EX` (0x200) and `redirect_ID` (0x300) in the same cycle -> next `imem_addr` = 0x200.
- **Ungranted request:** `imem_gnt` = 0 for 5 cycles -> `imem_addr` stable at 0x10; then `redirect_ID` to 0x40 -> `imem_addr` = 0x40 the next cycle; grant -> `pc_ID` = 0x40.
- **Async reset mid-WAIT:** `rst` low mid-WAIT -> outputs at reset values immediately; a `imem_rvalid` 2 cycles later (still before release) leaves `valid_ID` = 0 and `buf_valid` = 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bundle for the fetch stage
//
// Purpose: groups the fetch-side instruction-memory handshake so the fetch
// stage and the memory (or a bench model of it) share one port.
// Signals:
//   imem_req    fetch request valid (fetch -> memory)
//   imem_addr   fetch address, sampled by memory only on a grant cycle
//   imem_gnt    memory accepts the request this cycle
//   imem_rvalid response valid, never earlier than the cycle after the grant
//   imem_rdata  returned instruction word
// Modports: master = fetch stage, slave = instruction memory.

interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction-fetch stage with one-entry return buffer
//
// Purpose: owns the PC, keeps at most one instruction-memory request in
// flight, parks the returned word in a one-entry buffer and moves it into the
// IF/ID register when decode can take it. Redirects (EX over ID) and IF/ID
// flushes/stalls come from the hazard unit.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall_IF, flush_IF       hold / restart fetch
//   stall_ID, flush_ID       hold / bubble the IF/ID register
//   redirect_EX, target_EX   branch/jalr redirect (highest priority)
//   redirect_ID, target_ID   jal redirect
//   imem                     instruction-memory bundle (master side)
//   pc_ID, inst_ID, valid_ID IF/ID pipeline register

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_IF,
  input  logic                flush_IF,
  input  logic                stall_ID,
  input  logic                flush_ID,
  input  logic                redirect_EX,
  input  logic [31:0]         target_EX,
  input  logic                redirect_ID,
  input  logic [31:0]         target_ID,
  fetch_unit_if.master        imem,
  output logic [31:0]         pc_ID,
  output logic [31:0]         inst_ID,
  output logic                valid_ID
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // nothing in flight
    ST_WAIT = 2'd1,   // granted, response pending and still wanted
    ST_DROP = 2'd2    // granted, response pending but stale
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic        valid_id_q, valid_id_d;

  logic        redir;
  logic [31:0] redir_tgt;
  logic        drain;
  logic        req;
  logic        gnt_fire;
  logic        rsp_keep;

  // Shared control terms
  always_comb begin
    redir     = redirect_EX | redirect_ID;
    redir_tgt = redirect_EX ? target_EX : target_ID;
    drain     = buf_valid_q & ~stall_ID & ~flush_ID & ~redir;
    // A new request only when the buffer will have room at the response.
    // Gated by rst so nothing is requested while reset is held.
    req       = rst & (state_q == ST_IDLE) & (~buf_valid_q | drain)
                & ~redir & ~stall_IF;
    gnt_fire  = req & imem.imem_gnt;
    rsp_keep  = (state_q == ST_WAIT) & imem.imem_rvalid & ~redir & ~flush_IF;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_if_q;

  // Fetch FSM next state
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      ST_IDLE: begin
        // A response arriving here belongs to a request killed by reset.
        if (gnt_fire) begin
          req_pc_d = pc_if_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = ST_IDLE;
        end else if (redir | flush_IF) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem.imem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PC and return buffer: redirect > flush_IF > normal fetch
  always_comb begin
    pc_if_d     = pc_if_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;

    if (drain) begin
      buf_valid_d = 1'b0;
    end

    if (rsp_keep) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = req_pc_q;
      buf_inst_d  = imem.imem_rdata;
      pc_if_d     = req_pc_q + 32'd4;
    end

    if (redir) begin
      pc_if_d     = redir_tgt;
      buf_valid_d = 1'b0;
    end else if (flush_IF) begin
      // Restart from the oldest instruction decode has not consumed yet.
      buf_valid_d = 1'b0;
      if (buf_valid_q) begin
        pc_if_d = buf_pc_q;
      end else if (state_q == ST_WAIT) begin
        pc_if_d = req_pc_q;
      end
    end
  end

  // IF/ID register: flush_ID > stall_ID > drain > bubble
  always_comb begin
    pc_id_d    = pc_id_q;
    inst_id_d  = inst_id_q;
    valid_id_d = valid_id_q;
    if (flush_ID) begin
      valid_id_d = 1'b0;
      inst_id_d  = NOP;
    end else if (stall_ID) begin
      valid_id_d = valid_id_q;
    end else if (drain) begin
      pc_id_d    = buf_pc_q;
      inst_id_d  = buf_inst_q;
      valid_id_d = 1'b1;
    end else begin
      valid_id_d = 1'b0;
      inst_id_d  = NOP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_if_q     <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'd0;
      buf_inst_q  <= NOP;
      pc_id_q     <= 32'd0;
      inst_id_q   <= NOP;
      valid_id_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_if_q     <= pc_if_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      pc_id_q     <= pc_id_d;
      inst_id_q   <= inst_id_d;
      valid_id_q  <= valid_id_d;
    end
  end

  assign pc_ID    = pc_id_q;
  assign inst_ID  = inst_id_q;
  assign valid_ID = valid_id_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_IF, flush_IF, stall_ID, flush_ID;
  logic        redirect_EX, redirect_ID;
  logic [31:0] target_EX, target_ID;
  logic [31:0] pc_ID, inst_ID;
  logic        valid_ID;

  fetch_unit_if imem_bus ();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_IF(stall_IF),
    .flush_IF(flush_IF),
    .stall_ID(stall_ID),
    .flush_ID(flush_ID),
    .redirect_EX(redirect_EX),
    .target_EX(target_EX),
    .redirect_ID(redirect_ID),
    .target_ID(target_ID),
    .imem(imem_bus),
    .pc_ID(pc_ID),
    .inst_ID(inst_ID),
    .valid_ID(valid_ID)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Memory model: one response per grant, lat cycles after the grant cycle.
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_cnt  = 0;
  int          lat      = 1;
  logic        gnt_en   = 1'b1;
  logic [31:0] rd_xor   = 32'd0;
  logic        req_s, granted;
  logic [31:0] addr_s;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ rd_xor;
  endfunction

  task automatic clr_ctl();
    stall_IF = 0; flush_IF = 0; stall_ID = 0; flush_ID = 0;
    redirect_EX = 0; redirect_ID = 0; target_EX = 0; target_ID = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    imem_bus.imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_bus.imem_rdata  = imem_bus.imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    imem_bus.imem_gnt    = gnt_en;
    #1;
    req_s   = imem_bus.imem_req;
    addr_s  = imem_bus.imem_addr;
    granted = req_s & gnt_en;
    if (req_s) chk("no_req_while_busy", 32'(mem_pend), 0);
    @(posedge clk);
    if (imem_bus.imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (granted) begin
      mem_pend = 1'b1;
      mem_addr = addr_s;
      mem_cnt  = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr_ctl();
    gnt_en = 1'b1;
    lat = 1;
    mem_pend = 1'b0;
    cycle();
    cycle();
  endtask

  logic [31:0] exp_next, pp, pi;
  logic        pv, hold_req;
  logic [31:0] hold_addr;
  int          loads;

  initial begin
    rst = 1'b0;
    clr_ctl();
    imem_bus.imem_gnt = 0; imem_bus.imem_rvalid = 0; imem_bus.imem_rdata = 0;
    @(negedge clk);

    // Reset values and streaming, rdata = addr
    do_reset();
    chk("rst_valid", 32'(valid_ID), 0);
    chk("rst_inst", inst_ID, NOP);
    chk("rst_pc", pc_ID, 0);
    chk("rst_req", 32'(req_s), 0);
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (k == 1) begin
        chk("first_req", 32'(req_s), 1);
        chk("first_addr", addr_s, 0);
      end
      if (k >= 3 && (k % 2) == 1) begin
        chk("stream_valid", 32'(valid_ID), 1);
        chk("stream_pc", pc_ID, 32'((k - 3) * 2));
        chk("stream_inst", inst_ID, 32'((k - 3) * 2));
      end else begin
        chk("stream_bubble", 32'(valid_ID), 0);
      end
    end

    // Load-use stall with the buffer refilled to 8
    do_reset();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) cycle();
    chk("pre_stall_pc", pc_ID, 4);
    stall_IF = 1; stall_ID = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_req", 32'(req_s), 0);
      chk("stall_pc", pc_ID, 4);
      chk("stall_valid", 32'(valid_ID), 1);
    end
    clr_ctl();
    cycle();
    chk("unstall_addr", addr_s, 32'hC);
    chk("unstall_pc", pc_ID, 8);
    chk("unstall_valid", 32'(valid_ID), 1);
    cycle();
    cycle();
    chk("unstall_pc2", pc_ID, 32'hC);

    // Redirect while waiting, response arrives late and is dropped
    do_reset();
    rst = 1'b1;
    lat = 5;
    cycle();
    lat = 1;
    redirect_EX = 1; target_EX = 32'h100;
    cycle();
    chk("redir_req", 32'(req_s), 0);
    clr_ctl();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("drop_req", 32'(req_s), 0);
      chk("drop_valid", 32'(valid_ID), 0);
    end
    cycle();
    chk("after_drop_req", 32'(req_s), 1);
    chk("after_drop_addr", addr_s, 32'h100);
    chk("after_drop_valid", 32'(valid_ID), 0);
    cycle();
    chk("no_stale_valid", 32'(valid_ID), 0);
    cycle();
    chk("redir_pc", pc_ID, 32'h100);
    chk("redir_id_valid", 32'(valid_ID), 1);

    // Simultaneous redirects: EX wins
    do_reset();
    rst = 1'b1;
    redirect_EX = 1; target_EX = 32'h200;
    redirect_ID = 1; target_ID = 32'h300;
    cycle();
    chk("dual_redir_req", 32'(req_s), 0);
    clr_ctl();
    cycle();
    chk("dual_redir_addr", addr_s, 32'h200);

    // Ungranted request holds its address, then an ID redirect
    do_reset();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    gnt_en = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("ungnt_req", 32'(req_s), 1);
      chk("ungnt_addr", addr_s, 32'h10);
    end
    redirect_ID = 1; target_ID = 32'h40;
    cycle();
    clr_ctl();
    gnt_en = 1;
    cycle();
    chk("jal_req", 32'(req_s), 1);
    chk("jal_addr", addr_s, 32'h40);
    cycle();
    cycle();
    chk("jal_pc", pc_ID, 32'h40);
    chk("jal_valid", 32'(valid_ID), 1);

    // Asynchronous reset in WAIT; the late response must be ignored
    do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    lat = 3;
    cycle();
    chk("pre_areset_valid", 32'(valid_ID), 1);
    lat = 1;
    fork
      begin
        #2 rst = 1'b0;
        #1;
        chk("areset_valid", 32'(valid_ID), 0);
        chk("areset_inst", inst_ID, NOP);
        chk("areset_pc", pc_ID, 0);
        chk("areset_req", 32'(imem_bus.imem_req), 0);
      end
      cycle();
    join
    for (int k = 0; k < 3; k++) cycle();
    chk("areset_rsp_ignored", 32'(valid_ID), 0);
    rst = 1'b1;
    cycle();
    chk("post_areset_addr", addr_s, 0);
    chk("post_areset_bubble", 32'(valid_ID), 0);
    cycle();
    cycle();
    chk("post_areset_pc", pc_ID, 0);

    // Randomized run against an instruction-stream model: every instruction
    // entering ID is the successor of the previous one, or the latest
    // redirect target, and carries the memory word of its PC.
    do_reset();
    rd_xor = 32'h5A5A_0F0F;
    rst = 1'b1;
    exp_next = 32'h0;
    hold_req = 1'b0;
    hold_addr = 32'h0;
    loads = 0;
    for (int n = 0; n < 4000; n++) begin
      stall_IF    = ($urandom_range(0, 9) < 2);
      stall_ID    = ($urandom_range(0, 9) < 2);
      flush_ID    = ($urandom_range(0, 9) == 0);
      flush_IF    = flush_ID && ($urandom_range(0, 1) == 1);
      redirect_EX = ($urandom_range(0, 24) == 0);
      redirect_ID = ($urandom_range(0, 19) == 0);
      target_EX   = 32'($urandom_range(0, 1023)) << 2;
      target_ID   = 32'($urandom_range(0, 1023)) << 2;
      gnt_en      = ($urandom_range(0, 9) < 7);
      lat         = $urandom_range(1, 4);
      pv = valid_ID; pp = pc_ID; pi = inst_ID;
      cycle();
      if (stall_IF || redirect_EX || redirect_ID) chk("rnd_req_gated", 32'(req_s), 0);
      if (hold_req && req_s) chk("rnd_addr_stable", addr_s, hold_addr);
      hold_req  = req_s & ~gnt_en;
      hold_addr = addr_s;
      if (flush_ID) begin
        chk("rnd_flush_valid", 32'(valid_ID), 0);
        chk("rnd_flush_inst", inst_ID, NOP);
        chk("rnd_flush_pc", pc_ID, pp);
      end else if (stall_ID) begin
        chk("rnd_hold_valid", 32'(valid_ID), 32'(pv));
        chk("rnd_hold_pc", pc_ID, pp);
        chk("rnd_hold_inst", inst_ID, pi);
      end else if (valid_ID) begin
        chk("rnd_no_load_on_redir", 32'(redirect_EX | redirect_ID), 0);
        chk("rnd_pc", pc_ID, exp_next);
        chk("rnd_inst", inst_ID, mem_word(exp_next));
        exp_next = exp_next + 32'd4;
        loads++;
      end else begin
        chk("rnd_bubble_inst", inst_ID, NOP);
      end
      if (redirect_EX) exp_next = target_EX;
      else if (redirect_ID) exp_next = target_ID;
    end
    chk("rnd_progress", 32'(loads > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
